// File: rtl/jtvigil_pkg.sv
// Shared constants for the Vigilante colour mixer: layer palette prefixes,
// colour plane selects and the transparent pen.
package jtvigil_pkg;

    localparam int PALW      = 9;
    localparam int CW        = 5;
    localparam int BLANK_DLY = 2;

    localparam logic [1:0] SCR1_PFX = 2'b00;
    localparam logic [1:0] OBJ_PFX  = 2'b01;
    localparam logic [1:0] SCR2_PFX = 2'b10;

    localparam logic [1:0] PLANE_R = 2'd0;
    localparam logic [1:0] PLANE_G = 2'd1;
    localparam logic [1:0] PLANE_B = 2'd2;

    localparam logic [3:0] TRANSP_COL = 4'h0;

    function automatic logic is_opaque(input logic [3:0] col);
        return col != TRANSP_COL;
    endfunction

endpackage

// File: rtl/jtvigil_colmix_if.sv
// Video/CPU bundle between the layer pipelines, the CPU palette bus and the
// colour mixer. Pixel inputs are only meaningful on pxl_cen; the palette bus
// writes on any clk where pal_cs is high and cpu_wrn is low (no back-pressure).
interface jtvigil_colmix_if;
    import jtvigil_pkg::*;

    logic            pxl_cen;
    logic            LHBL;
    logic            LVBL;
    logic [PALW+1:0] cpu_addr;
    logic [7:0]      cpu_dout;
    logic            pal_cs;
    logic            cpu_wrn;
    logic [6:0]      scr1_pix;
    logic            scr1_prio;
    logic [6:0]      obj_pix;
    logic [6:0]      scr2_pix;
    logic            scr2_en;
    logic [CW-1:0]   red;
    logic [CW-1:0]   green;
    logic [CW-1:0]   blue;
    logic            LHBL_dly;
    logic            LVBL_dly;

    modport master (
        output pxl_cen, LHBL, LVBL, cpu_addr, cpu_dout, pal_cs, cpu_wrn,
               scr1_pix, scr1_prio, obj_pix, scr2_pix, scr2_en,
        input  red, green, blue, LHBL_dly, LVBL_dly
    );

    modport slave (
        input  pxl_cen, LHBL, LVBL, cpu_addr, cpu_dout, pal_cs, cpu_wrn,
               scr1_pix, scr1_prio, obj_pix, scr2_pix, scr2_en,
        output red, green, blue, LHBL_dly, LVBL_dly
    );

endinterface

// File: rtl/jtvigil_pal_ram.sv
// Simple dual-port palette plane: one write port, one enabled synchronous
// read port with read-first behaviour on address collisions.
module jtvigil_pal_ram #(
    parameter int AW = 9,
    parameter int DW = 5
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [2**AW];
    logic [DW-1:0] r_rdata;

    // Both updates are non-blocking, so a colliding read returns the old word.
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        if (i_re) r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/jtvigil_colmix.sv
// Layer priority select, palette lookup and blanking for the Vigilante video
// path. Three pxl_cen stages: index register, palette read, gated RGB output.
module jtvigil_colmix
    import jtvigil_pkg::*;
#(
    parameter int PALW      = jtvigil_pkg::PALW,
    parameter int CW        = jtvigil_pkg::CW,
    parameter int BLANK_DLY = jtvigil_pkg::BLANK_DLY
) (
    input  logic               clk,
    input  logic               rst,
    jtvigil_colmix_if.slave    bus
);

    logic            w_scr1_op, w_obj_op;
    logic [PALW-1:0] w_idx;
    logic            w_wr;
    logic            w_we_r, w_we_g, w_we_b;
    logic [CW-1:0]   w_rd_r, w_rd_g, w_rd_b;
    logic            w_show;
    logic            w_unused;

    logic [PALW-1:0] r_idx;
    logic [1:0]      r_blank [BLANK_DLY];
    logic [CW-1:0]   r_red, r_green, r_blue;
    logic            r_hb_dly, r_vb_dly;

    assign w_scr1_op = is_opaque(bus.scr1_pix[3:0]);
    assign w_obj_op  = is_opaque(bus.obj_pix[3:0]);
    assign w_unused  = ^bus.cpu_dout[7:5];

    always_comb begin
        w_idx = '0;
        if (w_scr1_op && bus.scr1_prio) w_idx = {SCR1_PFX, bus.scr1_pix};
        else if (w_obj_op)              w_idx = {OBJ_PFX,  bus.obj_pix};
        else if (w_scr1_op)             w_idx = {SCR1_PFX, bus.scr1_pix};
        else if (bus.scr2_en)           w_idx = {SCR2_PFX, bus.scr2_pix};
    end

    assign w_wr   = bus.pal_cs && !bus.cpu_wrn;
    assign w_we_r = w_wr && (bus.cpu_addr[PALW+1:PALW] == PLANE_R);
    assign w_we_g = w_wr && (bus.cpu_addr[PALW+1:PALW] == PLANE_G);
    assign w_we_b = w_wr && (bus.cpu_addr[PALW+1:PALW] == PLANE_B);

    jtvigil_pal_ram #(.AW(PALW), .DW(CW)) u_pal_r (
        .clk(clk), .i_we(w_we_r), .i_waddr(bus.cpu_addr[PALW-1:0]),
        .i_wdata(bus.cpu_dout[CW-1:0]), .i_re(bus.pxl_cen),
        .i_raddr(r_idx), .o_rdata(w_rd_r)
    );

    jtvigil_pal_ram #(.AW(PALW), .DW(CW)) u_pal_g (
        .clk(clk), .i_we(w_we_g), .i_waddr(bus.cpu_addr[PALW-1:0]),
        .i_wdata(bus.cpu_dout[CW-1:0]), .i_re(bus.pxl_cen),
        .i_raddr(r_idx), .o_rdata(w_rd_g)
    );

    jtvigil_pal_ram #(.AW(PALW), .DW(CW)) u_pal_b (
        .clk(clk), .i_we(w_we_b), .i_waddr(bus.cpu_addr[PALW-1:0]),
        .i_wdata(bus.cpu_dout[CW-1:0]), .i_re(bus.pxl_cen),
        .i_raddr(r_idx), .o_rdata(w_rd_b)
    );

    // The blank delay line covers stages 0-1; the output register then lines
    // the delayed blanks up with the colour they gate.
    assign w_show = r_blank[BLANK_DLY-1][1] && r_blank[BLANK_DLY-1][0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_idx    <= '0;
            for (int i = 0; i < BLANK_DLY; i++) r_blank[i] <= 2'b00;
            r_red    <= '0;
            r_green  <= '0;
            r_blue   <= '0;
            r_hb_dly <= 1'b0;
            r_vb_dly <= 1'b0;
        end else if (bus.pxl_cen) begin
            r_idx      <= w_idx;
            r_blank[0] <= {bus.LHBL, bus.LVBL};
            for (int i = 1; i < BLANK_DLY; i++) r_blank[i] <= r_blank[i-1];
            r_red    <= w_show ? w_rd_r : '0;
            r_green  <= w_show ? w_rd_g : '0;
            r_blue   <= w_show ? w_rd_b : '0;
            r_hb_dly <= r_blank[BLANK_DLY-1][1];
            r_vb_dly <= r_blank[BLANK_DLY-1][0];
        end
    end

    assign bus.red      = r_red;
    assign bus.green    = r_green;
    assign bus.blue     = r_blue;
    assign bus.LHBL_dly = r_hb_dly;
    assign bus.LVBL_dly = r_vb_dly;

endmodule

// File: tb/tb_jtvigil_colmix.sv
// Bench for jtvigil_colmix: directed priority/blanking/collision/reset cases
// plus randomized pixels and palette writes against a behavioural model.
module tb_jtvigil_colmix;
  import jtvigil_pkg::*;

  typedef struct packed {
    logic [8:0]  idx;
    logic        hb;
    logic        vb;
    logic [14:0] rgb;
  } rec_t;

  logic clk;
  logic rst;
  jtvigil_colmix_if bus();

  jtvigil_colmix dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [4:0]  pal_m [3][512];
  rec_t        pipe_q[$];
  logic [16:0] exp_out;
  int          tests_run;
  int          tests_failed;

  function automatic logic [8:0] ref_idx(input logic [6:0] s1, input logic pr,
                                         input logic [6:0] ob, input logic [6:0] s2,
                                         input logic en);
    if (s1[3:0] != 0 && pr) return 9'(s1);
    if (ob[3:0] != 0)       return 9'h080 + 9'(ob);
    if (s1[3:0] != 0)       return 9'(s1);
    if (en)                 return 9'h100 + 9'(s2);
    return 9'h000;
  endfunction

  // Called just after each rising edge, with the inputs of that edge still driven.
  task automatic model_edge();
    rec_t t;
    if (!rst) begin
      pipe_q.delete();
      exp_out = '0;
    end else if (bus.pxl_cen) begin
      // Previous pixel's palette read happens on this edge, before any write lands.
      if (pipe_q.size() > 0) begin
        t = pipe_q[pipe_q.size()-1];
        t.rgb = {pal_m[0][t.idx], pal_m[1][t.idx], pal_m[2][t.idx]};
        pipe_q[pipe_q.size()-1] = t;
      end
      t.idx = ref_idx(bus.scr1_pix, bus.scr1_prio, bus.obj_pix, bus.scr2_pix, bus.scr2_en);
      t.hb  = bus.LHBL;
      t.vb  = bus.LVBL;
      t.rgb = '0;
      pipe_q.push_back(t);
      if (pipe_q.size() > 3) void'(pipe_q.pop_front());
      if (pipe_q.size() == 3) begin
        t = pipe_q[0];
        exp_out = {(t.hb && t.vb) ? t.rgb : 15'h0, t.hb, t.vb};
      end else begin
        exp_out = '0;
      end
    end
    if (bus.pal_cs && !bus.cpu_wrn && bus.cpu_addr[10:9] != 2'd3)
      pal_m[bus.cpu_addr[10:9]][bus.cpu_addr[8:0]] = bus.cpu_dout[4:0];
  endtask

  // ---------------- scoreboard check ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [16:0] dut_out();
    return {bus.red, bus.green, bus.blue, bus.LHBL_dly, bus.LVBL_dly};
  endfunction

  // ---------------- driver tasks ----------------
  // Entered and left at a falling edge.
  task automatic tick(input bit cen, input bit wr, input logic [10:0] a, input logic [7:0] d);
    bus.pxl_cen  = cen;
    bus.pal_cs   = wr;
    bus.cpu_wrn  = !wr;
    bus.cpu_addr = a;
    bus.cpu_dout = d;
    @(posedge clk);
    model_edge();
    #1;
    if (cen && rst) check("pix", 32'(dut_out()), 32'(exp_out));
    @(negedge clk);
    bus.pxl_cen = 1'b0;
    bus.pal_cs  = 1'b0;
    bus.cpu_wrn = 1'b1;
  endtask

  task automatic pix_step();
    tick(1'b1, 1'b0, 11'h0, 8'h0);
    tick(1'b0, 1'b0, 11'h0, 8'h0);
  endtask

  task automatic wr_pal(input logic [1:0] plane, input logic [8:0] idx, input logic [7:0] d);
    tick(1'b0, 1'b1, {plane, idx}, d);
  endtask

  task automatic set_pix(input logic [6:0] s1, input logic pr, input logic [6:0] ob,
                         input logic [6:0] s2, input logic en);
    bus.scr1_pix  = s1;
    bus.scr1_prio = pr;
    bus.obj_pix   = ob;
    bus.scr2_pix  = s2;
    bus.scr2_en   = en;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    tests_run    = 0;
    tests_failed = 0;
    exp_out      = '0;
    rst          = 1'b0;
    bus.pxl_cen  = 1'b0;
    bus.LHBL     = 1'b1;
    bus.LVBL     = 1'b1;
    bus.cpu_addr = '0;
    bus.cpu_dout = '0;
    bus.pal_cs   = 1'b0;
    bus.cpu_wrn  = 1'b1;
    set_pix(7'h0, 1'b0, 7'h0, 7'h0, 1'b0);
    repeat (3) @(negedge clk);
    check("reset_out", 32'(dut_out()), 32'h0);
    rst = 1'b1;

    // Fill every palette entry so the model never sees unknown words.
    for (int p = 0; p < 3; p++)
      for (int i = 0; i < 512; i++)
        wr_pal(2'(p), 9'(i), 8'($urandom_range(0, 255)));
    wr_pal(PLANE_R, 9'h045, 8'h1F);
    wr_pal(PLANE_G, 9'h045, 8'h0A);
    wr_pal(PLANE_B, 9'h045, 8'hE3);  // upper bits must be dropped
    wr_pal(PLANE_R, 9'h092, 8'h05);
    wr_pal(PLANE_R, 9'h17F, 8'h1A);
    wr_pal(PLANE_R, 9'h000, 8'h07);

    // Basic lookup.
    set_pix(7'h45, 1'b0, 7'h00, 7'h00, 1'b0);
    repeat (3) pix_step();
    check("scr1_rgb", 32'({bus.red, bus.green, bus.blue}), 32'({5'h1F, 5'h0A, 5'h03}));

    // Object over scroll-1, then scroll-1 priority.
    set_pix(7'h45, 1'b0, 7'h12, 7'h00, 1'b0);
    repeat (3) pix_step();
    check("obj_wins", 32'(bus.red), 32'h05);
    set_pix(7'h45, 1'b1, 7'h12, 7'h00, 1'b0);
    repeat (3) pix_step();
    check("scr1_prio", 32'(bus.red), 32'h1F);

    // Background, and nothing at all.
    set_pix(7'h40, 1'b0, 7'h30, 7'h7F, 1'b1);
    repeat (3) pix_step();
    check("scr2_bg", 32'(bus.red), 32'h1A);
    set_pix(7'h40, 1'b0, 7'h30, 7'h7F, 1'b0);
    repeat (3) pix_step();
    check("no_layer", 32'(bus.red), 32'h07);

    // One-pixel horizontal blank.
    set_pix(7'h45, 1'b0, 7'h00, 7'h00, 1'b0);
    repeat (3) pix_step();
    bus.LHBL = 1'b0;
    pix_step();
    bus.LHBL = 1'b1;
    pix_step();
    check("pre_hblank", 32'({bus.red, bus.LHBL_dly}), 32'({5'h1F, 1'b1}));
    pix_step();
    check("hblank_rgb", 32'({bus.red, bus.green, bus.blue}), 32'h0);
    check("hblank_dly", 32'({bus.LHBL_dly, bus.LVBL_dly}), 32'b01);
    pix_step();
    check("post_hblank", 32'({bus.red, bus.LHBL_dly}), 32'({5'h1F, 1'b1}));

    // Write colliding with the stage-1 read of the same entry.
    set_pix(7'h45, 1'b0, 7'h12, 7'h00, 1'b0);
    pix_step();
    tick(1'b1, 1'b1, {PLANE_R, 9'h092}, 8'h11);
    tick(1'b0, 1'b0, 11'h0, 8'h0);
    pix_step();
    check("collide_old", 32'(bus.red), 32'h05);
    pix_step();
    check("collide_new", 32'(bus.red), 32'h11);
    wr_pal(2'd3, 9'h092, 8'h1F);
    repeat (3) pix_step();
    check("plane3_ignored", 32'(bus.red), 32'h11);

    // Asynchronous reset mid-frame; palette must survive.
    #2;
    rst = 1'b0;
    #1;
    check("rst_rgb", 32'({bus.red, bus.green, bus.blue}), 32'h0);
    check("rst_blank", 32'({bus.LHBL_dly, bus.LVBL_dly}), 32'h0);
    @(negedge clk);
    pipe_q.delete();
    exp_out = '0;
    pix_step();
    rst = 1'b1;
    pix_step();
    pix_step();
    check("post_rst_black", 32'(bus.red), 32'h0);
    pix_step();
    check("post_rst_col", 32'(bus.red), 32'h11);

    // Randomized pixels, blanks and palette traffic.
    for (int n = 0; n < 600; n++) begin
      logic [6:0]  s1, ob;
      logic [10:0] a;
      logic        wr;
      s1 = 7'($urandom_range(0, 127));
      ob = 7'($urandom_range(0, 127));
      if ($urandom_range(0, 2) == 0) s1[3:0] = 4'h0;
      if ($urandom_range(0, 2) == 0) ob[3:0] = 4'h0;
      set_pix(s1, 1'($urandom_range(0, 1)), ob, 7'($urandom_range(0, 127)),
              1'($urandom_range(0, 1)));
      bus.LHBL = ($urandom_range(0, 7) != 0);
      bus.LVBL = ($urandom_range(0, 15) != 0);
      a  = {2'($urandom_range(0, 3)), 9'($urandom_range(0, 511))};
      if ($urandom_range(0, 3) == 0 && pipe_q.size() > 0) a[8:0] = pipe_q[pipe_q.size()-1].idx;
      wr = ($urandom_range(0, 1) == 1);
      tick(1'b1, wr, a, 8'($urandom_range(0, 255)));
      repeat ($urandom_range(1, 3))
        tick(1'b0, ($urandom_range(0, 3) == 0),
             {2'($urandom_range(0, 3)), 9'($urandom_range(0, 511))},
             8'($urandom_range(0, 255)));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
